// File: rtl/roi_shr_pkg.sv
// Shared types and sizing helpers for the ROI serial harness driver.
package roi_shr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        STB_LOAD,
        REFILL,
        STB_CAP,
        DRAIN
    } state_e;

    localparam int DEFAULT_DIN_N  = 256;
    localparam int DEFAULT_DOUT_N = 256;

    // Down-counter width: enough for the longest timed phase, plus one bit of headroom.
    function automatic int cnt_width(input int din_n, input int dout_n, input int rx_lat);
        int span;
        span = (din_n > dout_n + rx_lat) ? din_n : (dout_n + rx_lat);
        return $clog2(span) + 1;
    endfunction

endpackage

// File: rtl/roi_shr_deser.sv
// Response deserializer: skips RX_LAT pipeline cycles, samples DOUT_N bits MSB first, latches rx_data.
module roi_shr_deser
    import roi_shr_pkg::*;
#(
    parameter int DOUT_N = DEFAULT_DOUT_N,
    parameter int RX_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ser_do,
    output logic [DOUT_N-1:0] rx_data,
    output logic              done
);

    localparam int            CW         = cnt_width(1, DOUT_N, RX_LAT);
    localparam logic [CW-1:0] DRAIN_CNT  = CW'(RX_LAT + DOUT_N - 1);
    localparam logic [CW-1:0] SAMPLE_LIM = CW'(DOUT_N);

    logic              active_q;
    logic [CW-1:0]     cnt_q;
    logic [DOUT_N-1:0] rxsr_q;
    logic [DOUT_N-1:0] rx_data_q;
    logic              done_q;
    logic [DOUT_N-1:0] rxsr_d;

    assign rxsr_d = {rxsr_q[DOUT_N-2:0], ser_do};

    // Counts below DOUT_N are sampling cycles; counts above are pipeline skip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q  <= 1'b0;
            cnt_q     <= '0;
            rxsr_q    <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                active_q <= 1'b1;
                cnt_q    <= DRAIN_CNT;
            end else if (active_q) begin
                if (cnt_q < SAMPLE_LIM) begin
                    rxsr_q <= rxsr_d;
                end
                if (cnt_q == '0) begin
                    active_q  <= 1'b0;
                    rx_data_q <= rxsr_d;
                    done_q    <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign rx_data = rx_data_q;
    assign done    = done_q;

endmodule

// File: rtl/roi_shr_driver.sv
// ROI serial harness driver: shifts a stimulus word in, strobes load and capture, drains the response.
// Optional build macro ROI_SHR_DRIVER_CNT_EN adds a 16-bit completed-transaction counter output txn_cnt.
module roi_shr_driver
    import roi_shr_pkg::*;
#(
    parameter int DIN_N  = DEFAULT_DIN_N,
    parameter int DOUT_N = DEFAULT_DOUT_N,
    parameter int RX_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIN_N-1:0]  tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DOUT_N-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              ser_di,
    output logic              ser_stb,
    input  logic              ser_do
`ifdef ROI_SHR_DRIVER_CNT_EN
    ,
    output logic [15:0]       txn_cnt
`endif
);

    localparam int            CW         = cnt_width(DIN_N, DOUT_N, RX_LAT);
    localparam logic [CW-1:0] SHIFT_CNT  = CW'(DIN_N - 1);
    localparam logic [CW-1:0] REFILL_CNT = CW'(DIN_N - 2);
    localparam logic [CW-1:0] DRAIN_CNT  = CW'(RX_LAT + DOUT_N - 1);

    state_e           state_q;
    logic [DIN_N-1:0] txsr_q;
    logic [CW-1:0]    cnt_q;
    logic             ser_stb_q;
    logic [DIN_N-1:0] txsr_d;
    logic             deser_done;

    assign txsr_d = {txsr_q[DIN_N-2:0], txsr_q[DIN_N-1]};

    // txsr makes 2*DIN_N rotations before STB_CAP so the harness refills with the same word;
    // it is cleared entering DRAIN so ser_di idles low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            txsr_q    <= '0;
            cnt_q     <= '0;
            ser_stb_q <= 1'b0;
        end else begin
            ser_stb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        state_q <= SHIFT;
                        txsr_q  <= tx_data;
                        cnt_q   <= SHIFT_CNT;
                    end
                end
                SHIFT: begin
                    txsr_q <= txsr_d;
                    if (cnt_q == '0) begin
                        state_q   <= STB_LOAD;
                        ser_stb_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STB_LOAD: begin
                    txsr_q  <= txsr_d;
                    state_q <= REFILL;
                    cnt_q   <= REFILL_CNT;
                end
                REFILL: begin
                    txsr_q <= txsr_d;
                    if (cnt_q == '0) begin
                        state_q   <= STB_CAP;
                        ser_stb_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                STB_CAP: begin
                    txsr_q  <= '0;
                    state_q <= DRAIN;
                    cnt_q   <= DRAIN_CNT;
                end
                DRAIN: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    roi_shr_deser #(
        .DOUT_N (DOUT_N),
        .RX_LAT (RX_LAT)
    ) u_deser (
        .clk     (clk),
        .rst     (rst),
        .start   (state_q == STB_CAP),
        .ser_do  (ser_do),
        .rx_data (rx_data),
        .done    (deser_done)
    );

`ifdef ROI_SHR_DRIVER_CNT_EN
    logic [15:0] txn_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn_cnt_q <= '0;
        end else if (deser_done) begin
            txn_cnt_q <= txn_cnt_q + 16'd1;
        end
    end

    assign txn_cnt = txn_cnt_q;
`endif

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign ser_di   = txsr_q[DIN_N-1];
    assign ser_stb  = ser_stb_q;
    assign rx_valid = deser_done;

endmodule
